instr_fetch_buf: RTL and testbench

- Fetch stage directly downstream of the program counter.
- Presents the current PC to the synchronous instruction ROM, which has 1-cycle read latency.
- Captures each returned instruction together with its address in a small FIFO and hands it to decode over a valid/ready handshake.
- Back-pressures the PC through its halt input, discards wrong-path fetches on branch/jump, and sequences start/stop of fetching.

---
 rtl/instr_fetch_buf.sv | 150 +++++++++++++++
 tb/tb_instr_fetch_buf.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_buf.sv
// ---------------------------------------------------------------------------
// instr_fetch_buf
// Fetch stage between the program counter and decode. Presents the PC to a
// synchronous ROM (1-cycle latency), captures {instr, addr} in a small FIFO,
// and hands the head to decode over valid/ready. Back-pressures the PC with
// hold_pc_if, drops wrong-path fetches on start/branch/stop, and sequences
// start/stop of fetching.
//
// Ports:
//   clk, rst_n      clock, async active-low reset
//   start_if        program start pulse (also restarts the PC at 0)
//   stop_if         halt instruction retired
//   flush_if        branch/jump taken this cycle
//   pc_addr_if      current PC
//   imem_addr_if    ROM address (combinational copy of pc_addr_if)
//   imem_ren_if     fetch request issued this cycle
//   imem_rdata_if   ROM data for last cycle's address
//   hold_pc_if      freezes the PC whenever no request is issued
//   dec_valid_if    FIFO head valid
//   dec_ready_if    decode accepts head
//   dec_instr_if    head instruction (0 while empty)
//   dec_pc_if       head address (0 while empty)
//   busy_if         running, FIFO non-empty, or request in flight
// ---------------------------------------------------------------------------
// state   | meaning
// IDLE    | after reset, no fetching until start_if
// RUN     | issuing fetches while credit is available
// STOPPED | halt retired, no fetching until start_if
// ---------------------------------------------------------------------------
module instr_fetch_buf #(
  parameter int ADDR_W  = 16,
  parameter int INSTR_W = 9,
  parameter int DEPTH   = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start_if,
  input  logic               stop_if,
  input  logic               flush_if,
  input  logic [ADDR_W-1:0]  pc_addr_if,
  output logic [ADDR_W-1:0]  imem_addr_if,
  output logic               imem_ren_if,
  input  logic [INSTR_W-1:0] imem_rdata_if,
  output logic               hold_pc_if,
  output logic               dec_valid_if,
  input  logic               dec_ready_if,
  output logic [INSTR_W-1:0] dec_instr_if,
  output logic [ADDR_W-1:0]  dec_pc_if,
  output logic               busy_if
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    STOPPED = 2'd2
  } state_t;

  state_t             state;
  logic [CNT_W-1:0]   count;
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic               req_q;
  logic [ADDR_W-1:0]  addr_q;

  logic [INSTR_W-1:0] instr_mem [DEPTH];
  logic [ADDR_W-1:0]  pc_mem    [DEPTH];

  logic               flush;
  logic               issue;
  logic               push;
  logic               pop;
  logic [CNT_W:0]     credit_used;

  // start_if restarts from any state; branch/stop only matter while running.
  assign flush = start_if | ((state == RUN) & (flush_if | stop_if));

  // Entries already held plus the one in flight must leave room for a new
  // request, so the FIFO can never be pushed while full.
  assign credit_used = {1'b0, count} + (CNT_W+1)'(req_q);
  assign issue = (state == RUN) && !start_if && !flush_if && !stop_if &&
                 (credit_used < (CNT_W+1)'(DEPTH));

  assign push = req_q && !flush;
  assign pop  = dec_valid_if && dec_ready_if;

  assign imem_addr_if = pc_addr_if;
  assign imem_ren_if  = issue;
  assign hold_pc_if   = !issue;
  assign dec_valid_if = (count != '0);
  assign dec_instr_if = dec_valid_if ? instr_mem[rd_ptr] : '0;
  assign dec_pc_if    = dec_valid_if ? pc_mem[rd_ptr]    : '0;
  assign busy_if      = (state == RUN) || dec_valid_if || req_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE:    if (start_if) state <= RUN;
        RUN: begin
          if (start_if)      state <= RUN;
          else if (flush_if) state <= RUN;
          else if (stop_if)  state <= STOPPED;
        end
        STOPPED: if (start_if) state <= RUN;
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      req_q  <= 1'b0;
      addr_q <= '0;
    end else begin
      req_q <= issue;
      if (issue) addr_q <= pc_addr_if;

      if (flush) begin
        count  <= '0;
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        // DEPTH is a power of two, so pointers wrap naturally.
        if (push) wr_ptr <= wr_ptr + PTR_W'(1);
        if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
        case ({push, pop})
          2'b10:   count <= count + CNT_W'(1);
          2'b01:   count <= count - CNT_W'(1);
          default: count <= count;
        endcase
      end
    end
  end

  // Storage carries no reset; its contents are only visible when count != 0.
  always_ff @(posedge clk) begin
    if (push) begin
      instr_mem[wr_ptr] <= imem_rdata_if;
      pc_mem[wr_ptr]    <= addr_q;
    end
  end

endmodule

// File: tb/tb_instr_fetch_buf.sv
// ---------------------------------------------------------------------------
// tb_instr_fetch_buf
// Bench for instr_fetch_buf with a behavioural PC and ROM around it. A
// program-order model predicts every address decode should receive: after
// start it is 0,1,2,...; a taken branch restarts the order at the target;
// stop ends it. Directed phases cover latency, throughput, back-pressure,
// flush, stop/restart, priority and async reset; a random phase follows.
// ---------------------------------------------------------------------------
module tb_instr_fetch_buf;

  localparam int ADDR_W  = 16;
  localparam int INSTR_W = 9;
  localparam int DEPTH   = 4;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               start_if = 1'b0;
  logic               stop_if = 1'b0;
  logic               flush_if = 1'b0;
  logic [ADDR_W-1:0]  pc_addr_if;
  logic [ADDR_W-1:0]  imem_addr_if;
  logic               imem_ren_if;
  logic [INSTR_W-1:0] imem_rdata_if;
  logic               hold_pc_if;
  logic               dec_valid_if;
  logic               dec_ready_if = 1'b0;
  logic [INSTR_W-1:0] dec_instr_if;
  logic [ADDR_W-1:0]  dec_pc_if;
  logic               busy_if;

  logic [ADDR_W-1:0]  br_tgt = '0;
  logic [ADDR_W-1:0]  pc_q;

  int total = 0;
  int bad = 0;

  // program-order model
  bit                 model_run = 1'b0;
  logic [ADDR_W-1:0]  exp_next = '0;
  int                 outstanding = 0;

  always #5 clk = ~clk;

  instr_fetch_buf #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W), .DEPTH(DEPTH)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start_if      (start_if),
    .stop_if       (stop_if),
    .flush_if      (flush_if),
    .pc_addr_if    (pc_addr_if),
    .imem_addr_if  (imem_addr_if),
    .imem_ren_if   (imem_ren_if),
    .imem_rdata_if (imem_rdata_if),
    .hold_pc_if    (hold_pc_if),
    .dec_valid_if  (dec_valid_if),
    .dec_ready_if  (dec_ready_if),
    .dec_instr_if  (dec_instr_if),
    .dec_pc_if     (dec_pc_if),
    .busy_if       (busy_if)
  );

  function automatic logic [INSTR_W-1:0] rom_f(input logic [ADDR_W-1:0] a);
    return a[8:0] ^ {2'b00, a[15:9]};
  endfunction

  // PC: restart at 0 on start, load target on branch, advance unless halted.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)          pc_q <= '0;
    else if (start_if)   pc_q <= '0;
    else if (flush_if)   pc_q <= br_tgt;
    else if (!hold_pc_if) pc_q <= pc_q + 16'd1;
  end
  assign pc_addr_if = pc_q;

  always @(posedge clk) imem_rdata_if <= rom_f(imem_addr_if);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  // Every decode transfer must be the next address in program order.
  always @(negedge clk) begin
    if (!rst_n) begin
      model_run   = 1'b0;
      exp_next    = '0;
      outstanding = 0;
    end else begin
      if (dec_valid_if && dec_ready_if) begin
        chk("pop_pc", 32'(dec_pc_if), 32'(exp_next));
        chk("pop_instr", 32'(dec_instr_if), 32'(rom_f(exp_next)));
        exp_next = exp_next + 16'd1;
      end
      if (!model_run && !start_if)
        chk("idle_ren", 32'(imem_ren_if), 32'd0);
      if (start_if) begin
        model_run   = 1'b1;
        exp_next    = '0;
        outstanding = 0;
      end else if (model_run && flush_if) begin
        exp_next    = br_tgt;
        outstanding = 0;
      end else if (model_run && stop_if) begin
        model_run   = 1'b0;
        outstanding = 0;
      end else begin
        outstanding = outstanding + int'(imem_ren_if) - int'(dec_valid_if && dec_ready_if);
      end
      chk("credit", 32'(outstanding <= DEPTH), 32'd1);
    end
  end

  initial begin
    int r;
    // reset state
    #22;
    chk("rst_valid", 32'(dec_valid_if), 32'd0);
    chk("rst_ren",   32'(imem_ren_if),  32'd0);
    chk("rst_hold",  32'(hold_pc_if),   32'd1);
    chk("rst_busy",  32'(busy_if),      32'd0);
    chk("rst_pc",    32'(dec_pc_if),    32'd0);
    chk("rst_instr", 32'(dec_instr_if), 32'd0);
    @(negedge clk);
    #1 rst_n = 1'b1;

    // streaming with ready held
    step();
    dec_ready_if = 1'b1;
    start_if = 1'b1;
    settle();
    chk("start_ren", 32'(imem_ren_if), 32'd0);
    step();
    start_if = 1'b0;
    settle();
    chk("first_ren",  32'(imem_ren_if),  32'd1);
    chk("first_addr", 32'(imem_addr_if), 32'd0);
    step();
    step();
    settle();
    chk("lat_valid", 32'(dec_valid_if), 32'd1);
    chk("lat_pc",    32'(dec_pc_if),    32'd0);
    chk("lat_instr", 32'(dec_instr_if), 32'(rom_f(16'd0)));
    for (int i = 1; i <= 2; i++) begin
      step();
      settle();
      chk("tput_valid", 32'(dec_valid_if), 32'd1);
      chk("tput_pc",    32'(dec_pc_if),    32'(i));
      chk("tput_hold",  32'(hold_pc_if),   32'd0);
    end

    // branch taken when PC reaches 5
    for (int k = 0; k < 20; k++) begin
      if (pc_q == 16'd5) break;
      step();
    end
    chk("flush_at_pc5", 32'(pc_q), 32'd5);
    flush_if = 1'b1;
    br_tgt = 16'h0020;
    settle();
    chk("flush_ren", 32'(imem_ren_if), 32'd0);
    step();
    flush_if = 1'b0;
    settle();
    chk("flush_valid1", 32'(dec_valid_if), 32'd0);
    chk("tgt_ren",      32'(imem_ren_if),  32'd1);
    chk("tgt_addr",     32'(imem_addr_if), 32'h20);
    step();
    settle();
    chk("flush_valid2", 32'(dec_valid_if), 32'd0);
    step();
    settle();
    chk("tgt_valid", 32'(dec_valid_if), 32'd1);
    chk("tgt_pc",    32'(dec_pc_if),    32'h20);

    // back-pressure: restart with decode stalled
    step();
    dec_ready_if = 1'b0;
    start_if = 1'b1;
    step();
    start_if = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      settle();
      chk("bp_hold", 32'(hold_pc_if), 32'(k >= 5));
      if (k >= 3) chk("bp_head", 32'(dec_pc_if), 32'd0);
      step();
    end
    dec_ready_if = 1'b1;
    for (int j = 0; j < 8; j++) begin
      settle();
      chk("drain_valid", 32'(dec_valid_if), 32'd1);
      chk("drain_pc",    32'(dec_pc_if),    32'(j));
      step();
    end

    // stop then restart
    stop_if = 1'b1;
    settle();
    chk("stop_ren",  32'(imem_ren_if), 32'd0);
    chk("stop_hold", 32'(hold_pc_if),  32'd1);
    step();
    stop_if = 1'b0;
    settle();
    chk("stopped_valid", 32'(dec_valid_if), 32'd0);
    chk("stopped_busy",  32'(busy_if),      32'd0);
    chk("stopped_hold",  32'(hold_pc_if),   32'd1);
    chk("stopped_ren",   32'(imem_ren_if),  32'd0);
    step(); step(); step();
    settle();
    chk("stopped_ren2", 32'(imem_ren_if), 32'd0);
    start_if = 1'b1;
    step();
    start_if = 1'b0;
    settle();
    chk("restart_ren",  32'(imem_ren_if),  32'd1);
    chk("restart_addr", 32'(imem_addr_if), 32'd0);
    step(); step();
    settle();
    chk("restart_pc", 32'(dec_pc_if), 32'd0);

    // start + flush + stop together behaves as start
    step(); step();
    start_if = 1'b1;
    flush_if = 1'b1;
    stop_if  = 1'b1;
    br_tgt = 16'h0077;
    settle();
    chk("all3_ren", 32'(imem_ren_if), 32'd0);
    step();
    start_if = 1'b0;
    flush_if = 1'b0;
    stop_if  = 1'b0;
    settle();
    chk("all3_next_ren",  32'(imem_ren_if),  32'd1);
    chk("all3_next_addr", 32'(imem_addr_if), 32'd0);
    chk("all3_valid",     32'(dec_valid_if), 32'd0);
    chk("all3_busy",      32'(busy_if),      32'd1);
    step(); step();
    settle();
    chk("all3_pc", 32'(dec_pc_if), 32'd0);

    // async reset with the FIFO full
    dec_ready_if = 1'b0;
    for (int k = 0; k < 8; k++) step();
    settle();
    chk("full_valid", 32'(dec_valid_if), 32'd1);
    chk("full_hold",  32'(hold_pc_if),   32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(dec_valid_if), 32'd0);
    chk("arst_hold",  32'(hold_pc_if),   32'd1);
    chk("arst_ren",   32'(imem_ren_if),  32'd0);
    chk("arst_busy",  32'(busy_if),      32'd0);
    @(negedge clk);
    #1 rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      settle();
      chk("post_rst_ren",  32'(imem_ren_if), 32'd0);
      chk("post_rst_busy", 32'(busy_if),     32'd0);
    end

    // random traffic
    for (int c = 0; c < 2000; c++) begin
      step();
      r = int'($urandom_range(0, 99));
      dec_ready_if = ($urandom_range(0, 3) != 0);
      br_tgt   = 16'($urandom);
      start_if = (r < 2) || (!model_run && r < 15);
      flush_if = model_run && (r >= 2) && (r < 6);
      stop_if  = model_run && (r >= 6) && (r < 8);
    end
    step();
    start_if = 1'b0;
    flush_if = 1'b0;
    stop_if  = 1'b0;
    dec_ready_if = 1'b1;
    for (int k = 0; k < 10; k++) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
